// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge commands, 0.1 s count-enable prescaler,
// chain clear, saturation at 9:59.9 and lap-split freeze for the display.
module stopwatch_ctrl #(
  parameter int unsigned DIV = 5_000_000,
  parameter bit          SAT = 1'b1
) (
  input  logic       clk,
  input  logic       r,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] cnt_q0,
  input  logic [7:0] cnt_qs,
  input  logic [3:0] cnt_qm,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] disp_q0,
  output logic [7:0] disp_qs,
  output logic [3:0] disp_qm,
  output logic [1:0] state,
  output logic       running,
  output logic       ovf
);

  localparam int unsigned    PW      = $clog2(DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   lap_q, lap_d;
  logic          btn_ss_d_q, btn_lr_d_q;
  logic          cnt_clr_q, cnt_clr_d;
  logic          ovf_q, ovf_d;

  logic ss_e, lr_e, active, tick, halt;

  // start/stop wins when both buttons rise together
  assign ss_e   = btn_ss & ~btn_ss_d_q;
  assign lr_e   = btn_lr & ~btn_lr_d_q & ~ss_e;
  assign active = (state_q == RUN) || (state_q == LAP);
  assign tick   = active && (pre_q == PRE_MAX);
  assign halt   = SAT && (cnt_qm == 4'd9) && (cnt_qs == 8'h59) && (cnt_q0 == 4'd9);

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      lap_q      <= '0;
      btn_ss_d_q <= 1'b0;
      btn_lr_d_q <= 1'b0;
      cnt_clr_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      lap_q      <= lap_d;
      btn_ss_d_q <= btn_ss;
      btn_lr_d_q <= btn_lr;
      cnt_clr_q  <= cnt_clr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    lap_d     = lap_q;
    cnt_clr_d = 1'b0;
    ovf_d     = ovf_q;
    if (active) pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    unique case (state_q)
      IDLE: if (ss_e) state_d = RUN;
      RUN: begin
        if (ss_e) state_d = STOP;
        else if (lr_e) begin
          state_d = LAP;
          lap_d   = {cnt_qm, cnt_qs, cnt_q0};
        end
      end
      LAP: begin
        if (ss_e)      state_d = STOP;
        else if (lr_e) state_d = RUN;
      end
      STOP: begin
        if (ss_e) state_d = RUN;
        else if (lr_e) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
          pre_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // a tick that would roll past 9:59.9 stops the watch instead
    if (tick && halt) begin
      state_d = STOP;
      ovf_d   = 1'b1;
    end
  end

  always_comb begin
    state   = state_q;
    running = active;
    cnt_en  = tick & ~halt;
    cnt_clr = cnt_clr_q;
    ovf     = ovf_q;
    if (state_q == LAP) {disp_qm, disp_qs, disp_q0} = lap_q;
    else                {disp_qm, disp_qs, disp_q0} = {cnt_qm, cnt_qs, cnt_q0};
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=4: saturating and wrapping instances,
// each driving a behavioural BCD chain that feeds back its live digits.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic r   = 1'b0;
  always #5 clk = ~clk;

  logic ss0 = 1'b0, lr0 = 1'b0, ss1 = 1'b0, lr1 = 1'b0;
  logic ld0 = 1'b0, ld1 = 1'b0;
  logic [15:0] ld0_val = '0, ld1_val = '0;
  logic [15:0] ch0, ch1;

  logic en0, clr0, run0, ovf0, en1, clr1, run1, ovf1;
  logic [1:0] st0, st1;
  logic [3:0] dq0_0, dqm_0, dq0_1, dqm_1;
  logic [7:0] dqs_0, dqs_1;
  logic [15:0] disp0, disp1;
  assign disp0 = {dqm_0, dqs_0, dq0_0};
  assign disp1 = {dqm_1, dqs_1, dq0_1};

  stopwatch_ctrl #(.DIV(4), .SAT(1'b1)) u0 (
    .clk(clk), .r(r), .btn_ss(ss0), .btn_lr(lr0),
    .cnt_q0(ch0[3:0]), .cnt_qs(ch0[11:4]), .cnt_qm(ch0[15:12]),
    .cnt_en(en0), .cnt_clr(clr0),
    .disp_q0(dq0_0), .disp_qs(dqs_0), .disp_qm(dqm_0),
    .state(st0), .running(run0), .ovf(ovf0));

  stopwatch_ctrl #(.DIV(4), .SAT(1'b0)) u1 (
    .clk(clk), .r(r), .btn_ss(ss1), .btn_lr(lr1),
    .cnt_q0(ch1[3:0]), .cnt_qs(ch1[11:4]), .cnt_qm(ch1[15:12]),
    .cnt_en(en1), .cnt_clr(clr1),
    .disp_q0(dq0_1), .disp_qs(dqs_1), .disp_qm(dqm_1),
    .state(st1), .running(run1), .ovf(ovf1));

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] m, t, u, d;
    {m, t, u, d} = v;
    if (d != 4'd9) d = d + 4'd1;
    else begin
      d = 4'd0;
      if (u != 4'd9) u = u + 4'd1;
      else begin
        u = 4'd0;
        if (t != 4'd5) t = t + 4'd1;
        else begin
          t = 4'd0;
          m = (m == 4'd9) ? 4'd0 : m + 4'd1;
        end
      end
    end
    return {m, t, u, d};
  endfunction

  always @(posedge clk or negedge r) begin
    if (!r)       ch0 <= '0;
    else if (ld0) ch0 <= ld0_val;
    else if (clr0) ch0 <= '0;
    else if (en0) ch0 <= bcd_inc(ch0);
  end

  always @(posedge clk or negedge r) begin
    if (!r)       ch1 <= '0;
    else if (ld1) ch1 <= ld1_val;
    else if (clr1) ch1 <= '0;
    else if (en1) ch1 <= bcd_inc(ch1);
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs sampled 1 ns later.
  task automatic cyc(input logic ss, input logic lr,
                     input logic s2 = 1'b0, input logic l2 = 1'b0);
    @(negedge clk);
    ss0 = ss; lr0 = lr; ss1 = s2; lr1 = l2;
    #1;
  endtask

  typedef struct {
    logic        ss, lr;
    logic [1:0]  st;
    logic        en;
    logic [15:0] disp, live;
  } vec_t;

  function automatic vec_t mk(input logic ss, input logic lr, input logic [1:0] st,
                              input logic en, input logic [15:0] disp, input logic [15:0] live);
    vec_t v;
    v.ss = ss; v.lr = lr; v.st = st; v.en = en; v.disp = disp; v.live = live;
    return v;
  endfunction

  vec_t tv[35];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // start, first ticks, lap freeze and release
    tv[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000);
    tv[1]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000);
    tv[2]  = mk(1, 0, 1, 0, 16'h0000, 16'h0000);
    tv[3]  = mk(0, 0, 1, 0, 16'h0000, 16'h0000);
    tv[4]  = mk(0, 0, 1, 0, 16'h0000, 16'h0000);
    tv[5]  = mk(0, 0, 1, 1, 16'h0000, 16'h0000);
    tv[6]  = mk(0, 0, 1, 0, 16'h0001, 16'h0001);
    tv[7]  = mk(0, 0, 1, 0, 16'h0001, 16'h0001);
    tv[8]  = mk(0, 0, 1, 0, 16'h0001, 16'h0001);
    tv[9]  = mk(0, 0, 1, 1, 16'h0001, 16'h0001);
    tv[10] = mk(0, 0, 1, 0, 16'h0002, 16'h0002);
    tv[11] = mk(0, 0, 1, 0, 16'h0002, 16'h0002);
    tv[12] = mk(0, 0, 1, 0, 16'h0002, 16'h0002);
    tv[13] = mk(0, 0, 1, 1, 16'h0002, 16'h0002);
    tv[14] = mk(0, 1, 1, 0, 16'h0003, 16'h0003);
    tv[15] = mk(0, 0, 3, 0, 16'h0003, 16'h0003);
    tv[16] = mk(0, 0, 3, 0, 16'h0003, 16'h0003);
    tv[17] = mk(0, 0, 3, 1, 16'h0003, 16'h0003);
    tv[18] = mk(0, 0, 3, 0, 16'h0003, 16'h0004);
    tv[19] = mk(0, 0, 3, 0, 16'h0003, 16'h0004);
    tv[20] = mk(0, 0, 3, 0, 16'h0003, 16'h0004);
    tv[21] = mk(0, 0, 3, 1, 16'h0003, 16'h0004);
    tv[22] = mk(0, 0, 3, 0, 16'h0003, 16'h0005);
    tv[23] = mk(0, 0, 3, 0, 16'h0003, 16'h0005);
    tv[24] = mk(0, 0, 3, 0, 16'h0003, 16'h0005);
    tv[25] = mk(0, 0, 3, 1, 16'h0003, 16'h0005);
    tv[26] = mk(0, 0, 3, 0, 16'h0003, 16'h0006);
    tv[27] = mk(0, 0, 3, 0, 16'h0003, 16'h0006);
    tv[28] = mk(0, 0, 3, 0, 16'h0003, 16'h0006);
    tv[29] = mk(0, 0, 3, 1, 16'h0003, 16'h0006);
    tv[30] = mk(0, 1, 3, 0, 16'h0003, 16'h0007);
    tv[31] = mk(0, 0, 1, 0, 16'h0007, 16'h0007);
    tv[32] = mk(0, 0, 1, 0, 16'h0007, 16'h0007);
    tv[33] = mk(0, 0, 1, 1, 16'h0007, 16'h0007);
    tv[34] = mk(0, 0, 1, 0, 16'h0008, 16'h0008);

    #2;
    chk("rst.state", 16'(st0), 16'd0);
    chk("rst.en",    16'(en0), 16'd0);
    chk("rst.clr",   16'(clr0), 16'd0);
    chk("rst.ovf",   16'(ovf0), 16'd0);
    chk("rst.disp",  disp0, ch0);
    @(negedge clk);
    r = 1'b1;

    for (int i = 0; i < 35; i++) begin
      cyc(tv[i].ss, tv[i].lr);
      chk($sformatf("v%0d.state", i), 16'(st0), 16'(tv[i].st));
      chk($sformatf("v%0d.en", i),    16'(en0), 16'(tv[i].en));
      chk($sformatf("v%0d.clr", i),   16'(clr0), 16'd0);
      chk($sformatf("v%0d.ovf", i),   16'(ovf0), 16'd0);
      chk($sformatf("v%0d.run", i),   16'(run0), 16'((tv[i].st == 2'd1) || (tv[i].st == 2'd3)));
      chk($sformatf("v%0d.disp", i),  disp0, tv[i].disp);
      chk($sformatf("v%0d.live", i),  ch0, tv[i].live);
    end

    // stop at pre=2 with button held, resume keeps phase
    cyc(1, 0); chk("hold.run", 16'(st0), 16'd1);
    for (int i = 0; i < 19; i++) begin
      cyc(1, 0);
      chk($sformatf("hold%0d.state", i), 16'(st0), 16'd2);
      chk($sformatf("hold%0d.en", i),    16'(en0), 16'd0);
    end
    cyc(0, 0); chk("rel.state", 16'(st0), 16'd2);
    cyc(1, 0); chk("res.state0", 16'(st0), 16'd2);
    cyc(0, 0); chk("res.en1", 16'(en0), 16'd0); chk("res.state1", 16'(st0), 16'd1);
    cyc(0, 0); chk("res.en2", 16'(en0), 16'd1);
    cyc(0, 0); chk("res.live", ch0, 16'h0009);

    // stop at 1:23.4 and clear
    cyc(1, 0); chk("stop.run", 16'(st0), 16'd1);
    cyc(0, 0); chk("stop.state", 16'(st0), 16'd2);
    ld0_val = 16'h1234; ld0 = 1'b1;
    cyc(0, 0); ld0 = 1'b0;
    chk("stop.disp", disp0, 16'h1234);
    cyc(0, 1); chk("clr.pre", 16'(clr0), 16'd0);
    cyc(0, 0); chk("clr.pulse", 16'(clr0), 16'd1); chk("clr.idle", 16'(st0), 16'd0);
    cyc(0, 0); chk("clr.end", 16'(clr0), 16'd0); chk("clr.live", ch0, 16'h0000);
    chk("clr.ovf", 16'(ovf0), 16'd0);
    cyc(0, 1); chk("idle.lr0", 16'(st0), 16'd0);
    cyc(0, 0); chk("idle.lr1", 16'(st0), 16'd0); chk("idle.clr", 16'(clr0), 16'd0);
    cyc(1, 0); chk("rst_pre.st", 16'(st0), 16'd0);
    cyc(0, 0); chk("rst_pre.en1", 16'(en0), 16'd0);
    cyc(0, 0); chk("rst_pre.en2", 16'(en0), 16'd0);
    cyc(0, 0); chk("rst_pre.en3", 16'(en0), 16'd0);
    cyc(0, 0); chk("rst_pre.en4", 16'(en0), 16'd1);

    // saturation at 9:59.9, then re-entry halts again
    ld0_val = 16'h9599; ld0 = 1'b1;
    cyc(0, 0); ld0 = 1'b0;
    chk("sat.disp", disp0, 16'h9599);
    cyc(0, 0); cyc(0, 0);
    cyc(0, 0); chk("sat.en", 16'(en0), 16'd0); chk("sat.st_run", 16'(st0), 16'd1);
    cyc(0, 0); chk("sat.state", 16'(st0), 16'd2); chk("sat.ovf", 16'(ovf0), 16'd1);
    chk("sat.hold", disp0, 16'h9599); chk("sat.running", 16'(run0), 16'd0);
    cyc(1, 0); chk("sat2.st0", 16'(st0), 16'd2);
    cyc(0, 0); chk("sat2.st1", 16'(st0), 16'd1);
    cyc(0, 0); cyc(0, 0);
    cyc(0, 0); chk("sat2.en", 16'(en0), 16'd0);
    cyc(0, 0); chk("sat2.state", 16'(st0), 16'd2); chk("sat2.ovf", 16'(ovf0), 16'd1);

    // wrapping instance rolls 9:59.9 over
    ld1_val = 16'h9599; ld1 = 1'b1;
    cyc(0, 0); ld1 = 1'b0;
    chk("wrap.load", disp1, 16'h9599);
    cyc(0, 0, 1, 0); chk("wrap.idle", 16'(st1), 16'd0);
    cyc(0, 0); chk("wrap.run", 16'(st1), 16'd1);
    cyc(0, 0); cyc(0, 0);
    cyc(0, 0); chk("wrap.en", 16'(en1), 16'd1);
    cyc(0, 0); chk("wrap.live", ch1, 16'h0000); chk("wrap.ovf", 16'(ovf1), 16'd0);
    chk("wrap.state", 16'(st1), 16'd1);

    // clear after overflow, simultaneous buttons, async reset in LAP
    cyc(0, 1);
    cyc(0, 0); chk("oclr.pulse", 16'(clr0), 16'd1);
    cyc(0, 0); chk("oclr.ovf", 16'(ovf0), 16'd0); chk("oclr.live", ch0, 16'h0000);
    cyc(1, 0);
    cyc(0, 0); cyc(0, 0);
    cyc(1, 1); chk("both.pre", 16'(st0), 16'd1);
    cyc(0, 0); chk("both.state", 16'(st0), 16'd2); chk("both.en", 16'(en0), 16'd0);
    cyc(1, 0);
    cyc(0, 0); chk("both.res_en", 16'(en0), 16'd1);
    cyc(0, 1); chk("lap2.live", ch0, 16'h0001);
    cyc(0, 0); chk("lap2.state", 16'(st0), 16'd3);
    cyc(0, 0); cyc(0, 0);
    cyc(0, 0); chk("lap2.disp", disp0, 16'h0001); chk("lap2.live2", ch0, 16'h0002);
    cyc(0, 0); cyc(0, 0);
    cyc(0, 0); chk("lap2.en", 16'(en0), 16'd1);
    r = 1'b0;
    #2;
    chk("arst.state", 16'(st0), 16'd0);
    chk("arst.en",    16'(en0), 16'd0);
    chk("arst.run",   16'(run0), 16'd0);
    chk("arst.disp",  disp0, 16'h0000);
    chk("arst.clr",   16'(clr0), 16'd0);
    @(negedge clk);
    r = 1'b1;
    cyc(0, 0); chk("post.state", 16'(st0), 16'd0); chk("post.en", 16'(en0), 16'd0);
    chk("post.live", ch0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
